// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multi-cycle RV32I core. Sequences FETCH, DECODE, EXEC,
//   MEM and WB. It decodes the instruction register into the execute-unit
//   operation code (alu_op, pc_update) and issues every datapath strobe and
//   mux select.
//
//   Optional feature macro: ILLEGAL_TRAP_EN
//     defined   : an unrecognised opcode in DECODE enters a TRAP state that
//                 raises the sticky illegal_instr flag and holds until rst.
//     undefined : no TRAP state, illegal_instr is tied low, and an
//                 unrecognised opcode retires as a NOP through EXEC.
//
//   Strobes and selects are decoded combinationally from the state register,
//   the instruction register and the mem_ready/bcond handshakes. A strobe
//   must act in the same cycle its handshake arrives. While rst is high every
//   output except the registered illegal_instr flag is forced to zero.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int ALU_CTRL_WIDTH = 5,
    parameter int INSTR_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INSTR_WIDTH-1:0]    instr,
    input  logic                      mem_ready,
    input  logic                      bcond,
    output logic [ALU_CTRL_WIDTH-1:0] alu_op,
    output logic                      pc_update,
    output logic [1:0]                alu_a_sel,
    output logic [1:0]                alu_b_sel,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic                      pc_src,
    output logic                      target_write,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      reg_write,
    output logic [1:0]                wb_sel,
    output logic                      instr_done,
    output logic                      illegal_instr
);

    // RV32I major opcodes recognised by this controller
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Operand A select encoding
    localparam logic [1:0] A_RS1    = 2'd0;
    localparam logic [1:0] A_OLD_PC = 2'd1;
    localparam logic [1:0] A_ZERO   = 2'd2;
    localparam logic [1:0] A_PC     = 2'd3;

    // Operand B select encoding
    localparam logic [1:0] B_RS2    = 2'd0;
    localparam logic [1:0] B_IMM    = 2'd1;
    localparam logic [1:0] B_FOUR   = 2'd2;

    // Writeback source encoding
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC    = 2'd2;

    // Instruction class derived from the opcode field
    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OPIMM   = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_AUIPC   = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_e;

    // Controller states; TRAP only exists when the trap feature is built in
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
`ifdef ILLEGAL_TRAP_EN
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
`else
        ST_WB     = 3'd4
`endif
    } state_e;

    // Map a major opcode onto its instruction class
    function automatic instr_class_e classify(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OPC_OP:     cls = CLS_OP;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Execute-unit operation code; the MSB marks the branch/LUI/JALR class.
    // Shift-right immediates are the only OP-IMM forms that use funct7[5].
    function automatic logic [ALU_CTRL_WIDTH-1:0] exec_op_code(
        input instr_class_e cls,
        input logic [2:0]   funct3,
        input logic         funct7_b5
    );
        logic [ALU_CTRL_WIDTH-1:0] code;
        case (cls)
            CLS_OP:     code = {1'b0, funct7_b5, funct3};
            CLS_OPIMM:  code = {1'b0, (funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
            CLS_BRANCH: code = {2'b10, funct3};
            CLS_JALR:   code = 5'b11001;
            CLS_LUI:    code = 5'b11000;
            default:    code = 5'b00000;
        endcase
        return code;
    endfunction

    state_e                    r_state;
    instr_class_e              w_class;
    logic [ALU_CTRL_WIDTH-1:0] w_exec_alu_op;
    logic [1:0]                w_exec_a_sel;
    logic [1:0]                w_exec_b_sel;
    logic                      w_is_load;
    logic                      w_is_store;
    logic                      w_unused_instr;

    assign w_class        = classify(instr[6:0]);
    assign w_exec_alu_op  = exec_op_code(w_class, instr[14:12], instr[30]);
    assign w_is_load      = (w_class == CLS_LOAD);
    assign w_is_store     = (w_class == CLS_STORE);
    // Register specifiers and immediate bits belong to the datapath only
    assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    assign illegal_instr = r_illegal;
`else
    assign illegal_instr = 1'b0;
`endif

    // Operand selects used in EXEC and held through MEM and WB
    always_comb begin
        w_exec_a_sel = A_RS1;
        w_exec_b_sel = B_RS2;
        case (w_class)
            CLS_OP: begin
                w_exec_a_sel = A_RS1;
                w_exec_b_sel = B_RS2;
            end
            CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JALR: begin
                w_exec_a_sel = A_RS1;
                w_exec_b_sel = B_IMM;
            end
            CLS_LUI: begin
                w_exec_a_sel = A_RS1;
                w_exec_b_sel = B_IMM;
            end
            CLS_AUIPC: begin
                w_exec_a_sel = A_OLD_PC;
                w_exec_b_sel = B_IMM;
            end
            CLS_BRANCH: begin
                w_exec_a_sel = A_RS1;
                w_exec_b_sel = B_RS2;
            end
            default: begin
                w_exec_a_sel = A_RS1;
                w_exec_b_sel = B_RS2;
            end
        endcase
    end

    // State sequencing and the sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state <= ST_DECODE;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                    if (w_class == CLS_ILLEGAL) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state   <= ST_EXEC;
                    end
`else
                    r_state <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    case (w_class)
                        CLS_LOAD, CLS_STORE:                   r_state <= ST_MEM;
                        CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC: r_state <= ST_WB;
                        default:                               r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (!mem_ready) begin
                        r_state <= ST_MEM;
                    end else if (w_is_load) begin
                        r_state <= ST_WB;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    r_state   <= ST_TRAP;
                    r_illegal <= 1'b1;
                end
`endif
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Datapath strobes and selects for the current state and instruction
    always_comb begin
        alu_op       = {ALU_CTRL_WIDTH{1'b0}};
        pc_update    = 1'b0;
        alu_a_sel    = A_RS1;
        alu_b_sel    = B_RS2;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        target_write = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        instr_done   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    // PC + 4 is formed while the instruction is read
                    mem_read  = 1'b1;
                    alu_a_sel = A_PC;
                    alu_b_sel = B_FOUR;
                    pc_update = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 1'b0;
                    end else begin
                        ir_write = 1'b0;
                        pc_write = 1'b0;
                    end
                end
                ST_DECODE: begin
                    // Speculative branch/jump target: old_pc + imm
                    alu_a_sel    = A_OLD_PC;
                    alu_b_sel    = B_IMM;
                    pc_update    = 1'b1;
                    target_write = 1'b1;
                end
                ST_EXEC: begin
                    alu_op    = w_exec_alu_op;
                    alu_a_sel = w_exec_a_sel;
                    alu_b_sel = w_exec_b_sel;
                    case (w_class)
                        CLS_BRANCH: begin
                            pc_write   = bcond;
                            pc_src     = bcond;
                            instr_done = 1'b1;
                        end
                        CLS_JAL: begin
                            pc_write   = 1'b1;
                            pc_src     = 1'b1;
                            reg_write  = 1'b1;
                            wb_sel     = WB_PC;
                            instr_done = 1'b1;
                        end
                        CLS_JALR: begin
                            // Link value is the PC before this cycle's update
                            pc_write   = 1'b1;
                            pc_src     = 1'b0;
                            reg_write  = 1'b1;
                            wb_sel     = WB_PC;
                            instr_done = 1'b1;
                        end
                        CLS_ILLEGAL: begin
                            // Retire as a NOP; PC was already advanced in FETCH
                            instr_done = 1'b1;
                        end
                        default: begin
                            instr_done = 1'b0;
                        end
                    endcase
                end
                ST_MEM: begin
                    alu_op    = w_exec_alu_op;
                    alu_a_sel = w_exec_a_sel;
                    alu_b_sel = w_exec_b_sel;
                    if (w_is_load) begin
                        mem_read = 1'b1;
                    end else if (w_is_store) begin
                        mem_write  = 1'b1;
                        instr_done = mem_ready;
                    end else begin
                        mem_read = 1'b0;
                    end
                end
                ST_WB: begin
                    alu_op     = w_exec_alu_op;
                    alu_a_sel  = w_exec_a_sel;
                    alu_b_sel  = w_exec_b_sel;
                    reg_write  = 1'b1;
                    wb_sel     = w_is_load ? WB_MEM : WB_ALU;
                    instr_done = 1'b1;
                end
                default: begin
                    // TRAP and unused encodings drive no strobes
                    alu_a_sel = A_RS1;
                end
            endcase
        end else begin
            alu_op    = {ALU_CTRL_WIDTH{1'b0}};
            alu_a_sel = A_RS1;
            alu_b_sel = B_RS2;
        end
    end

endmodule
